regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle core's integer register file.
- Two combinational read ports and one synchronous write port; register 0 can be configured as hardwired zero.
- Per-register busy scoreboard so a pipelined core can detect pending writebacks.
- Sequential clear engine: zeroes the whole file on request, one entry per cycle, with a busy/done handshake.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, >= 2.
- AW, $clog2(NREG), address width; derived, not overridden.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs1_addr  in  AW  read port A address.
- rs2_addr  in  AW  read port B address.
- rs1_data  out  XLEN  read port A data.
- rs2_data  out  XLEN  read port B data.
- rs1_busy  out  1  scoreboard bit for rs1_addr.
- rs2_busy  out  1  scoreboard bit for rs2_addr.
- rd_addr  in  AW  writeback address.
- wb_data  in  XLEN  writeback data.
- reg_write  in  1  writeback enable.
- issue_valid  in  1  instruction issued with a destination register.
- issue_rd  in  AW  destination of the issued instruction.
- clear_req  in  1  request full-file clear; sampled in IDLE only.
- clear_busy  out  1  high while the clear engine runs.
- clear_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (async, immediate) sets:
  - all registers 0, all busy bits 0;
  - FSM = IDLE, clear index 0;
  - clear_busy = 0, clear_done = 0.
  - rs*_data then read 0 and rs*_busy read 0.
- Reads: combinational from the current array contents.
  - If ZERO_REG=1 and addr==0, data=0 and busy=0 regardless of storage.
- Write: on posedge clk when reg_write=1 and FSM=IDLE, regs[rd_addr] <= wb_data.
  - Suppressed when ZERO_REG=1 and rd_addr==0.
  - Written value is visible on the read ports the cycle after the edge (no bypass unless the optional feature is enabled).
- Scoreboard, evaluated on posedge clk, IDLE only:
  - issue_valid sets busy[issue_rd].
  - reg_write clears busy[rd_addr].
  - Same index in the same cycle: set wins, because a new producer is in flight.
  - issue_rd==0 with ZERO_REG=1: ignored.
- FSM states:
  - IDLE: clear_busy=0. On clear_req=1 -> CLEAR; index <= 0; all busy bits <= 0 on the same edge.
  - CLEAR: clear_busy=1. Each edge sets regs[index] <= 0 and index <= index+1. When index==NREG-1 -> DONE. Lasts exactly NREG cycles.
  - DONE: clear_busy=0, clear_done=1 for exactly one cycle. -> IDLE.
- During CLEAR/DONE:
  - reg_write, issue_valid and clear_req are ignored (no queueing).
  - Reads remain live and return partially cleared contents.
- Index counter is AW bits wide and wraps to 0 naturally after NREG-1.
- Reset asserted mid-clear aborts immediately; no clear_done pulse.
- Total clear latency: clear_req sampled at edge T -> clear_done high in cycle T+NREG+1 (counted in cycles after T).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined, in IDLE with reg_write=1 and rd_addr==rsN_addr (and not the hardwired zero register):
  - rsN_data = wb_data, combinational write-first forwarding;
  - rsN_busy = 0 that cycle, unless issue_valid targets the same index that cycle.
- When undefined:
  - reads return stored contents only;
  - busy reflects the registered scoreboard only;
  - no wb_data-to-output combinational path exists.

Test Plan:
- Reset then read: assert rst mid-cycle with random prior contents -> all rs*_data=0 and rs*_busy=0 immediately, without waiting for clk.
- Write/read, defaults:
  - write x5=0xDEADBEEF, x0=0x12345678 -> next cycle rs1_addr=5 reads 0xDEADBEEF, rs2_addr=0 reads 0;
  - with ZERO_REG=0, rs2_addr=0 reads 0x12345678.
- Scoreboard:
  - issue_rd=7 -> rs1_busy=1 at addr 7 next cycle;
  - writeback rd=7 -> busy 0 next cycle;
  - same-cycle issue_rd=7 and writeback rd=7 -> busy stays 1 and x7 updated.
- Clear, NREG=32:
  - fill x1..x31 with index*3, pulse clear_req -> clear_busy high for 32 cycles, then clear_done pulse for 1 cycle;
  - all reads 0; reg_write of x4=0xAA during CLEAR has no effect.
- Reset mid-clear: assert rst at CLEAR cycle 10 -> clear_busy=0 immediately, no clear_done; FSM returns to IDLE; new clear_req accepted.
- Bypass:
  - REGFILE_BYPASS_EN defined: reg_write x9=0x55AA55AA with rs1_addr=9 -> rs1_data=0x55AA55AA in the same cycle.
  - Undefined: old value that cycle, new value the next.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file: 2 combinational read ports, 1 write port, per-register busy
// scoreboard, and a sequential clear engine. Define REGFILE_BYPASS_EN for write-first read forwarding.
module regfile_sb #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            reg_write,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            clear_req,
  output logic            clear_busy,
  output logic            clear_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_e;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_e                     state_q, state_d;
  logic [AW-1:0]              idx_q, idx_d;
  logic [NREG-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [NREG-1:0]            busy_q, busy_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      regs_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    regs_d     = regs_q;
    busy_d     = busy_q;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reg_write && !is_zero(rd_addr)) regs_d[rd_addr] = wb_data;
        if (clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          busy_d  = '0;
        end else begin
          // Set after clear so a same-cycle reissue keeps the register pending.
          if (reg_write) busy_d[rd_addr] = 1'b0;
          if (issue_valid && !is_zero(issue_rd)) busy_d[issue_rd] = 1'b1;
        end
      end
      S_CLEAR: begin
        clear_busy     = 1'b1;
        regs_d[idx_q]  = '0;
        idx_d          = idx_q + AW'(1);
        if (idx_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        clear_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rs1_data = is_zero(rs1_addr) ? '0 : regs_q[rs1_addr];
    rs2_data = is_zero(rs2_addr) ? '0 : regs_q[rs2_addr];
    rs1_busy = is_zero(rs1_addr) ? 1'b0 : busy_q[rs1_addr];
    rs2_busy = is_zero(rs2_addr) ? 1'b0 : busy_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (!rst && state_q == S_IDLE && reg_write) begin
      if (rd_addr == rs1_addr && !is_zero(rs1_addr)) begin
        rs1_data = wb_data;
        rs1_busy = issue_valid && (issue_rd == rs1_addr);
      end
      if (rd_addr == rs2_addr && !is_zero(rs2_addr)) begin
        rs2_data = wb_data;
        rs2_busy = issue_valid && (issue_rd == rs2_addr);
      end
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized + directed bench for regfile_sb; runs a ZERO_REG=1 and a ZERO_REG=0
// instance side by side against an array-based reference model.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr, issue_rd;
  logic [XLEN-1:0] wb_data;
  logic reg_write, issue_valid, clear_req;
  logic [XLEN-1:0] rs1_d[2], rs2_d[2];
  logic rs1_b[2], rs2_b[2], cb[2], cd[2];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_d[0]), .rs2_data(rs2_d[0]), .rs1_busy(rs1_b[0]), .rs2_busy(rs2_b[0]),
    .rd_addr(rd_addr), .wb_data(wb_data), .reg_write(reg_write),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .clear_req(clear_req),
    .clear_busy(cb[0]), .clear_done(cd[0]));

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(0)) u_n (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_d[1]), .rs2_data(rs2_d[1]), .rs1_busy(rs1_b[1]), .rs2_busy(rs2_b[1]),
    .rd_addr(rd_addr), .wb_data(wb_data), .reg_write(reg_write),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .clear_req(clear_req),
    .clear_busy(cb[1]), .clear_done(cd[1]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 clearing (clr_left entries to go), 2 done pulse
  logic [XLEN-1:0] m_regs[2][NREG];
  bit   m_busy[2][NREG];
  int   mode, clr_left;
  bit   seen_busy, seen_done;

  function automatic bit zr(int z, int a);
    return (z == 0) && (a == 0);
  endfunction

  function automatic bit fwd(int z, int a);
    return BYP && !rst && mode == 0 && reg_write && rd_addr == a && !zr(z, a);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int z, int a);
    if (rst || zr(z, a)) return '0;
    if (fwd(z, a)) return wb_data;
    return m_regs[z][a];
  endfunction

  function automatic bit exp_busy(int z, int a);
    if (rst || zr(z, a)) return 1'b0;
    if (fwd(z, a)) return issue_valid && issue_rd == a;
    return m_busy[z][a];
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < NREG; i++) begin m_regs[z][i] = '0; m_busy[z][i] = 1'b0; end
    mode = 0; clr_left = 0;
  endtask

  task automatic model_edge();
    if (rst) begin model_reset(); return; end
    if (mode == 0) begin
      for (int z = 0; z < 2; z++) begin
        if (reg_write && !zr(z, rd_addr)) m_regs[z][rd_addr] = wb_data;
        if (clear_req) for (int i = 0; i < NREG; i++) m_busy[z][i] = 1'b0;
        else begin
          if (reg_write) m_busy[z][rd_addr] = 1'b0;
          if (issue_valid && !zr(z, issue_rd)) m_busy[z][issue_rd] = 1'b1;
        end
      end
      if (clear_req) begin mode = 1; clr_left = NREG; end
    end else if (mode == 1) begin
      for (int z = 0; z < 2; z++) m_regs[z][NREG - clr_left] = '0;
      clr_left--;
      if (clr_left == 0) mode = 2;
    end else mode = 0;
  endtask

  task automatic check_all();
    for (int z = 0; z < 2; z++) begin
      chk($sformatf("u%0d.rs1_data[%0d]", z, rs1_addr), rs1_d[z], exp_data(z, rs1_addr));
      chk($sformatf("u%0d.rs2_data[%0d]", z, rs2_addr), rs2_d[z], exp_data(z, rs2_addr));
      chk($sformatf("u%0d.rs1_busy[%0d]", z, rs1_addr), rs1_b[z], exp_busy(z, rs1_addr));
      chk($sformatf("u%0d.rs2_busy[%0d]", z, rs2_addr), rs2_b[z], exp_busy(z, rs2_addr));
      chk($sformatf("u%0d.clear_busy", z), cb[z], !rst && mode == 1);
      chk($sformatf("u%0d.clear_done", z), cd[z], !rst && mode == 2);
    end
    seen_busy = cb[0];
    seen_done = cd[0];
  endtask

  // Inputs are driven at posedge+1; outputs checked mid-cycle; model advances on the edge.
  task automatic cycle();
    #4 check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    reg_write = 0; issue_valid = 0; clear_req = 0;
  endtask

  task automatic rand_in(input int clr_pct);
    rs1_addr = AW'($urandom); rs2_addr = AW'($urandom);
    rd_addr = AW'($urandom); issue_rd = AW'($urandom);
    if ($urandom_range(3) == 0) rd_addr = rs1_addr;
    if ($urandom_range(3) == 0) issue_rd = rd_addr;
    wb_data = $urandom; reg_write = $urandom_range(1);
    issue_valid = ($urandom_range(9) < 4);
    clear_req = ($urandom_range(99) < clr_pct);
  endtask

  task automatic async_reset();
    idle_in();
    #2 rst = 1;
    #1 check_all();
    for (int z = 0; z < 2; z++) begin
      chk("rst_rs1_data", rs1_d[z], 0);
      chk("rst_rs1_busy", rs1_b[z], 0);
      chk("rst_clear_busy", cb[z], 0);
    end
    @(posedge clk); model_edge(); #1;
    rst = 0;
  endtask

  initial begin
    int nb, nd;
    model_reset();
    rst = 1; idle_in();
    rs1_addr = 3; rs2_addr = 0; rd_addr = 0; issue_rd = 0; wb_data = 0;
    cycle(); cycle();
    rst = 0;

    // random fill, then async reset mid-cycle
    for (int i = 0; i < 60; i++) begin rand_in(0); issue_valid = 1; cycle(); end
    rand_in(0);
    async_reset();

    // directed write/read
    idle_in(); reg_write = 1; rd_addr = 5; wb_data = 32'hDEADBEEF; cycle();
    rd_addr = 0; wb_data = 32'h12345678; cycle();
    idle_in(); rs1_addr = 5; rs2_addr = 0;
    #2 chk("x5_read", rs1_d[0], 32'hDEADBEEF);
    chk("x0_zero_reg1", rs2_d[0], 0);
    chk("x0_zero_reg0", rs2_d[1], 32'h12345678);
    cycle();

    // scoreboard
    issue_valid = 1; issue_rd = 7; rs1_addr = 7; cycle();
    idle_in();
    #2 chk("busy_set", rs1_b[0], 1);
    cycle();
    reg_write = 1; rd_addr = 7; wb_data = 32'h70; cycle();
    idle_in();
    #2 chk("busy_clr", rs1_b[0], 0);
    cycle();
    reg_write = 1; rd_addr = 7; wb_data = 32'h77; issue_valid = 1; issue_rd = 7; cycle();
    idle_in();
    #2 chk("busy_set_wins", rs1_b[0], 1);
    chk("x7_updated", rs1_d[0], 32'h77);
    cycle();

    // bypass / no bypass
    reg_write = 1; rd_addr = 9; wb_data = 32'h1; cycle();
    wb_data = 32'h55AA55AA; rs1_addr = 9;
    #2 chk("x9_same_cycle", rs1_d[0], BYP ? 32'h55AA55AA : 32'h1);
    cycle();
    idle_in();
    #2 chk("x9_next_cycle", rs1_d[0], 32'h55AA55AA);
    cycle();

    // random traffic including clears
    for (int i = 0; i < 600; i++) begin rand_in(3); cycle(); end
    idle_in();
    for (int i = 0; i < 40 && mode != 0; i++) cycle();
    chk("model_idle", mode, 0);

    // full clear with a write attempt in flight
    for (int i = 1; i < NREG; i++) begin
      reg_write = 1; rd_addr = AW'(i); wb_data = i * 3; cycle();
    end
    idle_in(); clear_req = 1; cycle();
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      idle_in();
      if (i == 3) begin reg_write = 1; rd_addr = 4; wb_data = 32'hAA; clear_req = 1; issue_valid = 1; issue_rd = 4; end
      rs1_addr = AW'($urandom); rs2_addr = AW'(i);
      cycle();
      nb += seen_busy; nd += seen_done;
    end
    chk("clear_busy_cycles", nb, NREG);
    chk("clear_done_cycles", nd, 1);
    idle_in(); rs1_addr = 4; rs2_addr = 31;
    #2 chk("x4_after_clear", rs1_d[0], 0);
    chk("x31_after_clear", rs2_d[0], 0);
    chk("x4_busy_after_clear", rs1_b[0], 0);
    cycle();

    // reset during clear, then a fresh clear is accepted
    reg_write = 1; rd_addr = 12; wb_data = 32'hC0FFEE; cycle();
    idle_in(); clear_req = 1; cycle();
    idle_in();
    for (int i = 0; i < 9; i++) cycle();
    async_reset();
    nd = 0;
    for (int i = 0; i < 5; i++) begin cycle(); nd += seen_done; end
    chk("no_done_after_abort", nd, 0);
    clear_req = 1; cycle();
    idle_in();
    #2 chk("clear_restart", cb[0], 1);
    for (int i = 0; i < 40; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
